// File: rtl/bar_pkg.sv
// Shared types for the spectrum bar-height generator.
package bar_pkg;

   typedef enum logic [1:0] {
      COLLECT,
      HOLD,
      UPDATE
   } state_t;

   typedef logic [9:0]  coord_t;
   typedef logic [15:0] mag_t;

endpackage

// File: rtl/bar_decay_unit.sv
// Combinational next-height rule for one bar; peak-hold decay is enabled by
// defining BAR_PEAK_DECAY_EN, otherwise the new height replaces the old one.
module bar_decay_unit
   import bar_pkg::*;
#(
   parameter int unsigned DECAY_STEP = 4
) (
   input  logic [9:0] old_height,
   input  logic [9:0] new_height,
   output logic [9:0] next_height
);

`ifdef BAR_PEAK_DECAY_EN
   coord_t decayed;

   always_comb begin
      // Fall by DECAY_STEP but stop at 0 rather than wrapping.
      decayed     = (old_height > coord_t'(DECAY_STEP)) ? old_height - coord_t'(DECAY_STEP) : '0;
      next_height = (new_height > decayed) ? new_height : decayed;
   end
`else
   logic unused_old;

   assign unused_old  = ^old_height;
   assign next_height = new_height;
`endif

endmodule

// File: rtl/bar_height_gen.sv
// Collects one spectrum frame of bin magnitudes, then on frame_tick sweeps the
// bars one per cycle through bar_decay_unit. Optional build macro: BAR_PEAK_DECAY_EN.
module bar_height_gen
   import bar_pkg::*;
#(
   parameter int unsigned BAR_COUNT  = 16,
   parameter int unsigned BAR_WIDTH  = 40,
   parameter int unsigned BASE_Y     = 479,
   parameter int unsigned MAX_HEIGHT = 400,
   parameter int unsigned MAG_SHIFT  = 6,
   parameter int unsigned DECAY_STEP = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mag_valid,
   output logic        mag_ready,
   input  logic [15:0] mag_data,
   input  logic        mag_last,
   input  logic        frame_tick,
   output logic [9:0]  bar_x      [BAR_COUNT-1:0],
   output logic [9:0]  bar_y      [BAR_COUNT-1:0],
   output logic [9:0]  bar_height [BAR_COUNT-1:0],
   output logic [9:0]  bar_width,
   output logic        frame_done
);

   localparam int unsigned     IdxW     = $clog2(BAR_COUNT + 1);
   localparam logic [IdxW-1:0] CountIdx = IdxW'(BAR_COUNT);
   localparam logic [IdxW-1:0] LastIdx  = IdxW'(BAR_COUNT - 1);

   state_t          state_q, state_d;
   logic [IdxW-1:0] idx_q, idx_d;
   logic [IdxW-1:0] upd_q, upd_d;
   coord_t          pending_q [BAR_COUNT-1:0];
   coord_t          pending_d [BAR_COUNT-1:0];
   coord_t          height_q  [BAR_COUNT-1:0];
   coord_t          height_d  [BAR_COUNT-1:0];
   logic            frame_done_q, frame_done_d;

   mag_t   shifted;
   coord_t sample_height;
   coord_t sel_old, sel_new, next_height;

   always_comb begin
      shifted       = mag_data >> MAG_SHIFT;
      sample_height = (shifted > mag_t'(MAX_HEIGHT)) ? coord_t'(MAX_HEIGHT) : shifted[9:0];
   end

   // One decay unit serves the whole sweep; upd_q picks the bar.
   always_comb begin
      sel_old = '0;
      sel_new = '0;
      for (int i = 0; i < BAR_COUNT; i++) begin
         if (upd_q == IdxW'(i)) begin
            sel_old = height_q[i];
            sel_new = pending_q[i];
         end
      end
   end

   bar_decay_unit #(
      .DECAY_STEP (DECAY_STEP)
   ) u_decay (
      .old_height  (sel_old),
      .new_height  (sel_new),
      .next_height (next_height)
   );

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      upd_d        = upd_q;
      pending_d    = pending_q;
      height_d     = height_q;
      frame_done_d = 1'b0;
      mag_ready    = (state_q == COLLECT);

      unique case (state_q)
         COLLECT: begin
            if (mag_valid) begin
               for (int i = 0; i < BAR_COUNT; i++) begin
                  if (idx_q == IdxW'(i)) pending_d[i] = sample_height;
               end
               // Extra bins beyond BAR_COUNT are accepted but dropped.
               if (idx_q != CountIdx) idx_d = idx_q + 1'b1;
               if (mag_last) state_d = HOLD;
            end
         end
         HOLD: begin
            if (frame_tick) begin
               state_d = UPDATE;
               upd_d   = '0;
            end
         end
         UPDATE: begin
            for (int i = 0; i < BAR_COUNT; i++) begin
               if (upd_q == IdxW'(i)) height_d[i] = next_height;
            end
            upd_d = upd_q + 1'b1;
            if (upd_q == LastIdx) begin
               state_d      = COLLECT;
               idx_d        = '0;
               upd_d        = '0;
               frame_done_d = 1'b1;
               for (int i = 0; i < BAR_COUNT; i++) pending_d[i] = '0;
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= COLLECT;
         idx_q        <= '0;
         upd_q        <= '0;
         frame_done_q <= 1'b0;
         for (int i = 0; i < BAR_COUNT; i++) begin
            pending_q[i] <= '0;
            height_q[i]  <= '0;
         end
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         upd_q        <= upd_d;
         frame_done_q <= frame_done_d;
         pending_q    <= pending_d;
         height_q     <= height_d;
      end
   end

   for (genvar g = 0; g < BAR_COUNT; g++) begin : g_bar
      assign bar_x[g]      = 10'(g * BAR_WIDTH);
      assign bar_y[g]      = 10'(BASE_Y);
      assign bar_height[g] = height_q[g];
   end

   assign bar_width  = 10'(BAR_WIDTH);
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bar_height_gen.sv
// Scoreboard bench for bar_height_gen: stimulus pushes the expected bar heights
// per frame, a monitor pops and compares them on every frame_done.
module tb_bar_height_gen;

   typedef logic [15:0][9:0] frame_t;

`ifdef BAR_PEAK_DECAY_EN
   localparam bit Decay = 1'b1;
`else
   localparam bit Decay = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mag_valid, mag_ready, mag_last, frame_tick, frame_done;
   logic [15:0] mag_data;
   logic [9:0]  bar_x      [15:0];
   logic [9:0]  bar_y      [15:0];
   logic [9:0]  bar_height [15:0];
   logic [9:0]  bar_width;

   frame_t      exp_q [$];
   frame_t      mon_exp;
   logic [15:0] stim  [$];
   int          n_vec = 0;
   int          n_err = 0;
   int          frame_no = 0;

   always #5 clk = ~clk;

   bar_height_gen dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mag_valid  (mag_valid),
      .mag_ready  (mag_ready),
      .mag_data   (mag_data),
      .mag_last   (mag_last),
      .frame_tick (frame_tick),
      .bar_x      (bar_x),
      .bar_y      (bar_y),
      .bar_height (bar_height),
      .bar_width  (bar_width),
      .frame_done (frame_done)
   );

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic frame_t fill(input int v);
      frame_t f;
      for (int i = 0; i < 16; i++) f[i] = 10'(v);
      return f;
   endfunction

   task automatic fill_stim(input int n, input logic [15:0] v);
      for (int k = 0; k < n; k++) stim.push_back(v);
   endtask

   // Monitor: every frame_done must match exactly one queued expectation.
   always @(negedge clk) begin
      if (rst_n && frame_done) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL spurious frame_done: got 1, expected 0");
         end else begin
            mon_exp = exp_q.pop_front();
            frame_no++;
            for (int i = 0; i < 16; i++)
               check($sformatf("frame%0d bar%0d", frame_no, i), int'(bar_height[i]),
                     int'(mon_exp[i]));
         end
      end
   end

   task automatic send_frame();
      for (int k = 0; k < stim.size(); k++) begin
         @(negedge clk);
         mag_valid = 1'b1;
         mag_data  = stim[k];
         mag_last  = (k == stim.size() - 1);
         if (!mag_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL mag_ready sample %0d: got 0, expected 1", k);
         end
         @(posedge clk);
      end
      @(negedge clk);
      mag_valid = 1'b0;
      mag_last  = 1'b0;
      stim.delete();
   endtask

   task automatic pulse_tick();
      @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
   endtask

   task automatic wait_done();
      int w = 0;
      while (!frame_done && w < 40) begin
         @(negedge clk);
         w++;
      end
      check("frame_done seen", int'(frame_done), 1);
      @(negedge clk);
      check("frame_done one cycle", int'(frame_done), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      frame_t e;
      rst_n      = 1'b0;
      mag_valid  = 1'b0;
      mag_last   = 1'b0;
      mag_data   = '0;
      frame_tick = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 16; i++) check($sformatf("reset bar%0d", i), int'(bar_height[i]), 0);
      check("reset frame_done", int'(frame_done), 0);
      rst_n = 1'b1;
      #1;
      check("ready after reset", int'(mag_ready), 1);
      check("bar_width", int'(bar_width), 40);
      check("bar_x[3]", int'(bar_x[3]), 120);
      check("bar_y[7]", int'(bar_y[7]), 479);

      // Frame 1: 0x1900 >> 6 = 100, with per-bar update timing.
      fill_stim(16, 16'h1900);
      send_frame();
      check("ready in HOLD", int'(mag_ready), 0);
      exp_q.push_back(fill(100));
      pulse_tick();
      check("bar0 before sweep", int'(bar_height[0]), 0);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         check($sformatf("sweep bar%0d", i), int'(bar_height[i]), 100);
         if (i < 15) check($sformatf("sweep bar%0d early", i + 1), int'(bar_height[i + 1]), 0);
      end
      @(negedge clk);
      check("frame_done one cycle f1", int'(frame_done), 0);

      // Tick while collecting is ignored.
      pulse_tick();
      repeat (20) @(negedge clk);
      check("collect tick bar0", int'(bar_height[0]), 100);
      check("collect tick bar15", int'(bar_height[15]), 100);

      fill_stim(16, 16'h0000);
      send_frame();
      exp_q.push_back(fill(Decay ? 96 : 0));
      pulse_tick();
      wait_done();

      fill_stim(16, 16'h0000);
      send_frame();
      exp_q.push_back(fill(Decay ? 92 : 0));
      pulse_tick();
      wait_done();

      fill_stim(16, 16'hFFFF);
      send_frame();
      exp_q.push_back(fill(400));
      pulse_tick();
      wait_done();

      // Short frame: unwritten bars see pending 0.
      stim = '{16'h0040, 16'h0080, 16'h1000, 16'h0FFF, 16'h0000};
      send_frame();
      e = fill(0);
      e[0] = 10'd1;
      e[1] = 10'd2;
      e[2] = 10'd64;
      e[3] = 10'd63;
      exp_q.push_back(Decay ? fill(396) : e);
      pulse_tick();
      wait_done();

      // Long frame: bins 16..19 would saturate if not dropped; tick mid-sweep ignored.
      for (int k = 0; k < 16; k++) stim.push_back(16'((k + 1) << 6));
      fill_stim(4, 16'hFFFF);
      send_frame();
      for (int i = 0; i < 16; i++) e[i] = 10'(i + 1);
      exp_q.push_back(Decay ? fill(392) : e);
      pulse_tick();
      repeat (5) @(negedge clk);
      pulse_tick();
      wait_done();
      repeat (20) @(negedge clk);

      // Reset mid-sweep clears heights immediately.
      fill_stim(16, 16'h1900);
      send_frame();
      pulse_tick();
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      for (int i = 0; i < 16; i++) check($sformatf("mid reset bar%0d", i), int'(bar_height[i]), 0);
      check("mid reset frame_done", int'(frame_done), 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("ready after mid reset", int'(mag_ready), 1);

      // 2 then zeros: decay must clamp at 0.
      fill_stim(16, 16'h0080);
      send_frame();
      exp_q.push_back(fill(2));
      pulse_tick();
      wait_done();

      fill_stim(16, 16'h0000);
      send_frame();
      exp_q.push_back(fill(0));
      pulse_tick();
      wait_done();

      repeat (5) @(negedge clk);
      check("scoreboard drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/bar_height_gen.md
BAR_HEIGHT_GEN -- requirements
Module: bar_height_gen

Interface
REQ-001 Parameter BAR_COUNT, default 16, number of bars driven.
REQ-002 Parameter BAR_WIDTH, default 40, horizontal pitch of each bar in pixels.
REQ-003 Parameter BASE_Y, default 479, bottom row of every bar.
REQ-004 Parameter MAX_HEIGHT, default 400, height saturation limit.
REQ-005 Parameter MAG_SHIFT, default 6, right shift from magnitude to pixel height.
REQ-006 Parameter DECAY_STEP, default 4, pixels of fall per frame.
REQ-007 Clk  in  1  single clock; Reset_n  in  1  asynchronous active-low reset.
REQ-008 mag_valid  in  1; mag_ready  out  1; mag_data  in  16  unsigned bin magnitude; mag_last  in  1  marks the final bin of a spectrum frame.
REQ-009 frame_tick  in  1  one-cycle pulse at the start of vertical blanking.
REQ-010 bar_x, bar_y, bar_height  out  10 each, arrays [BAR_COUNT-1:0]; bar_width  out  10; frame_done  out  1.

Function
REQ-011 Transfer SHALL occur on a rising Clk edge where mag_valid and mag_ready are both 1.
REQ-012 States SHALL be COLLECT, HOLD and UPDATE; mag_ready SHALL be 1 only in COLLECT.
REQ-013 In COLLECT, the k-th accepted sample (k from 0) SHALL write pending[k] = min(mag_data >> MAG_SHIFT, MAX_HEIGHT) when k < BAR_COUNT. Samples with k >= BAR_COUNT SHALL be accepted and discarded, and the index SHALL saturate at BAR_COUNT.
REQ-014 An accepted sample with mag_last=1 SHALL move the state to HOLD. Bars not written in that frame SHALL keep pending = 0.
REQ-015 frame_tick in HOLD SHALL move the state to UPDATE on the next edge. frame_tick in COLLECT or UPDATE SHALL be ignored, and outputs SHALL hold.
REQ-016 UPDATE SHALL last exactly BAR_COUNT cycles. For a tick sampled at edge t, bar_height[i] SHALL update at edge t+1+i.
REQ-017 At edge t+BAR_COUNT the state SHALL return to COLLECT, and the write index and all pending entries SHALL be cleared to 0. frame_done SHALL be 1 for exactly that following cycle.
REQ-018 bar_x[i] SHALL be the constant i*BAR_WIDTH, bar_y[i] SHALL be the constant BASE_Y, and bar_width SHALL be the constant BAR_WIDTH.
REQ-019 All height arithmetic SHALL be unsigned 10-bit and SHALL saturate at 0 and at MAX_HEIGHT, with no wrap.

Reset
REQ-020 Reset_n low SHALL force, asynchronously: state COLLECT, index 0, all pending 0, all bar_height 0, frame_done 0. mag_ready SHALL be 1 once Reset_n is high.
REQ-021 Reset during UPDATE or HOLD SHALL discard the partial frame; bar_height SHALL read 0 immediately.

Configuration
REQ-022 With BAR_PEAK_DECAY_EN defined, an update SHALL write bar_height[i] = max(pending[i], bar_height[i] - DECAY_STEP), where the subtraction saturates at 0.
REQ-023 Without BAR_PEAK_DECAY_EN, an update SHALL write bar_height[i] = pending[i]. All timing SHALL be identical in both builds.

Structure
REQ-024 Package bar_pkg SHALL hold the state enum (COLLECT/HOLD/UPDATE), the 10-bit coordinate typedef and the 16-bit magnitude typedef.
REQ-025 The decay/saturate function SHALL live in a combinational sub-module bar_decay_unit (inputs old, new; output next), with one instance shared across the UPDATE sweep.

Verification
REQ-026 Reset release, then 16 samples of 0x1900 with mag_last on the 16th, then frame_tick. Required: mag_ready 0 after the 16th sample, all bar_height = 100 after 16 cycles, one-cycle frame_done.
REQ-027 A mag_data of 0xFFFF SHALL produce bar_height = 400 (saturation).
REQ-028 BAR_PEAK_DECAY_EN build: heights 100, then a frame of all zeros. Required: heights 96, then 92 on the next frame; a 2 followed by a zero frame SHALL give 0, not wrap.
REQ-029 A 5-sample frame with mag_last on sample 4: bars 0–4 SHALL be set and bars 5–15 SHALL be 0 (no-decay build). 20-sample frame: samples 16–19 SHALL be dropped and bars 0–15 SHALL be correct.
REQ-030 frame_tick during COLLECT and mid-UPDATE SHALL leave the outputs unchanged and SHALL produce no extra frame_done.
REQ-031 Reset_n asserted at UPDATE cycle 5 SHALL zero all heights asynchronously; the next full frame after release SHALL update normally.
